// File: rtl/adc_8_to_udp_32bit_pkg.sv
// ---------------------------------------------------------------------------
// adc_8_to_udp_32bit_pkg
//   Shared definitions for the ADC-to-UDP transmit path:
//     - default packet size and FIFO address width
//     - transmit FSM state encoding (2-bit)
//     - MSB-first byte placement helper used by the sample packer
// ---------------------------------------------------------------------------
package adc_8_to_udp_32bit_pkg;

  // 32-bit words per UDP packet; payload bytes = 4 * PKT_WORDS.
  localparam int unsigned PKT_WORDS_DEF = 256;

  // Word FIFO address width; depth = 2**FIFO_AW, must hold two packets.
  localparam int unsigned FIFO_AW_DEF = 9;

  // Transmit handshake FSM.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  // Byte order: the first byte of a group of four lands in [31:24], so byte
  // slot 'sel' occupies bits [31-8*sel -: 8]. This matches the unpack order
  // used on the receive (32->8) side.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  sel,
                                             input logic [7:0]  data);
    logic [31:0] r;
    r = word;
    r[8*(3-int'(sel)) +: 8] = data;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_w32.sv
// ---------------------------------------------------------------------------
// sync_fifo_w32
//   Single-clock 32-bit word FIFO with a registered read port (dout updates
//   the cycle after rd_en). Writes into a full FIFO and reads from an empty
//   FIFO are ignored, so the caller can decide how to treat them.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     wr_en, din   push din when not full
//     rd_en, dout  pop head into dout (registered) when not empty
//     full, empty  occupancy flags
//     count        number of stored words, AW+1 bits (0 .. 2**AW)
// ---------------------------------------------------------------------------
module sync_fifo_w32 #(
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [31:0]   din,
  input  logic          rd_en,
  output logic [31:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [31:0]   dout_q,   dout_d;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = dout_q;

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem[rd_ptr_q];
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers and count, so stale contents are never observable and the
  // array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignment only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/adc_8_to_udp_32bit.sv
// ---------------------------------------------------------------------------
// adc_8_to_udp_32bit
//   Transmit-side counterpart of the UDP 32->8 DAC path. ADC bytes are packed
//   MSB-first into 32-bit words, buffered in a word FIFO, and handed to the
//   UDP transmit engine one full packet at a time through its start/request
//   handshake.
//
//   Ports
//     clk          system clock (single domain)
//     rst_n        asynchronous active-low reset
//     adc_valid    adc_data carries a sample this cycle
//     adc_data     8-bit ADC sample
//     tx_busy      UDP engine is sending a packet
//     tx_req       UDP engine wants the next payload word
//     tx_start_en  one-cycle pulse that starts a packet
//     tx_byte_num  payload length in bytes (PKT_WORDS*4), constant
//     tx_data      payload word, valid the cycle after tx_req
//     overflow     sticky: a completed word was dropped on a full FIFO
// ---------------------------------------------------------------------------
module adc_8_to_udp_32bit
  import adc_8_to_udp_32bit_pkg::*;
#(
  parameter int unsigned PKT_WORDS = PKT_WORDS_DEF,
  parameter int unsigned FIFO_AW   = FIFO_AW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_valid,
  input  logic [7:0]  adc_data,
  input  logic        tx_busy,
  input  logic        tx_req,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  output logic        overflow
);

  localparam int unsigned CW  = FIFO_AW + 1;
  localparam int unsigned WCW = $clog2(PKT_WORDS + 1);

  // Two full packets must fit so one can fill while the other drains.
  if ((1 << FIFO_AW) < 2 * PKT_WORDS) begin : g_depth_check
    $error("FIFO depth must be at least 2*PKT_WORDS");
  end

  // -------------------------------------------------------------------------
  // Sample packer
  // -------------------------------------------------------------------------
  logic [1:0]  byte_sel_q,   byte_sel_d;
  logic [31:0] word_q,       word_d;
  logic        wr_pending_q, wr_pending_d;
  logic        overflow_q,   overflow_d;

  // FIFO interface
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_dout;
  logic          pop;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    byte_sel_d   = byte_sel_q;
    word_d       = word_q;
    wr_pending_d = 1'b0;
    if (adc_valid) begin
      word_d       = place_byte(word_q, byte_sel_q, adc_data);
      byte_sel_d   = byte_sel_q + 2'd1;
      wr_pending_d = (byte_sel_q == 2'd3);
    end
  end

  // The completed word is pushed on the edge after its 4th byte. A byte of
  // the next word arriving on that same edge only overwrites word_q after
  // the FIFO has sampled the finished value.
  assign overflow_d = overflow_q | (wr_pending_q & fifo_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_sel_q   <= '0;
      word_q       <= '0;
      wr_pending_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      byte_sel_q   <= byte_sel_d;
      word_q       <= word_d;
      wr_pending_q <= wr_pending_d;
      overflow_q   <= overflow_d;
    end
  end

  // -------------------------------------------------------------------------
  // Word FIFO
  // -------------------------------------------------------------------------
  sync_fifo_w32 #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_pending_q),
    .din   (word_q),
    .rd_en (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // -------------------------------------------------------------------------
  // Transmit handshake FSM and word counter
  // -------------------------------------------------------------------------
  tx_state_e      state_q,    state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic           pkt_ready;

  assign pkt_ready = (fifo_count >= CW'(PKT_WORDS));

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pkt_ready && !tx_busy) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        word_cnt_d = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        // An empty FIFO here means the handshake was violated; suppressing
        // the pop keeps tx_data and the pointers intact.
        if (tx_req && !fifo_empty) begin
          pop        = 1'b1;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == WCW'(PKT_WORDS - 1)) begin
            state_d = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign tx_start_en = (state_q == ST_START);
  assign tx_byte_num = 16'(PKT_WORDS * 4);
  assign tx_data     = fifo_dout;
  assign overflow    = overflow_q;

  // A request while sending must always find a buffered word.
  a_req_not_empty : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == ST_SEND && tx_req) |-> !fifo_empty
  );

endmodule
